controller_packetizer: RTL and testbench

//  Collects button states from NUM_CH controller readers and frames them as UDP-payload word bursts for network_stack_tx.

---
 rtl/controller_packetizer.sv | 158 +++++++++++++++
 tb/tb_controller_packetizer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/controller_packetizer.sv
// controller_packetizer
// Frames button states from NUM_CH controller readers into UDP-payload word
// bursts for network_stack_tx. A packet goes out when any channel differs
// from the value last sent, or as a keepalive after a long idle stretch.
// Packet: one header word {seq, NUM_CH}, then one word per channel
// {ch, zero-padded buttons}. axiov stays high for the whole packet.

module controller_packetizer #(
    parameter int NUM_CH           = 2,
    parameter int BTN_W            = 8,
    parameter int WORD_W           = 16,
    parameter int KEEPALIVE_CYCLES = 5_000_000,
    parameter int GAP_CYCLES       = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         ch_valid,
    input  logic [NUM_CH*BTN_W-1:0]   ch_buttons,
    input  logic                      tx_ready,
    output logic                      axiov,
    output logic [WORD_W-1:0]         axiod,
    output logic [7:0]                seq_out
);

    localparam int TMR_W = $clog2(KEEPALIVE_CYCLES);
    localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

    localparam logic [7:0]       LAST_CH  = 8'(NUM_CH - 1);
    localparam logic [7:0]       NUM_CH_B = 8'(NUM_CH);
    localparam logic [TMR_W-1:0] KA_MAX   = TMR_W'(KEEPALIVE_CYCLES - 1);
    // The cycle spent in IDLE deciding to start counts as one of the
    // low cycles, so GAP itself lasts GAP_CYCLES-1 cycles. A pending change
    // therefore starts the next header exactly GAP_CYCLES cycles after the
    // last word of the previous packet.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_HEADER,
        S_CHAN,
        S_GAP
    } state_t;

    state_t                    state;
    logic [NUM_CH*BTN_W-1:0]   cur;
    logic [NUM_CH*BTN_W-1:0]   sent;
    logic [TMR_W-1:0]          timer;
    logic [GAP_W-1:0]          gap_cnt;
    logic [7:0]                ch;
    logic [7:0]                seq;

    logic                      dirty;
    logic                      ka;
    logic                      start;
    logic [7:0]                word_idx;
    logic [7:0]                btn_ext;
    logic [WORD_W-1:0]         header_word;
    logic [WORD_W-1:0]         chan_word;

    // Latest sample per channel; older samples are simply overwritten.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_valid[c]) begin
                    cur[c*BTN_W +: BTN_W] <= ch_buttons[c*BTN_W +: BTN_W];
                end
            end
        end
    end

    // Trigger decode and the next word to put on the bus.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path leaves a variable unassigned, which would infer a latch.
        word_idx = 8'd0;
        btn_ext  = '0;
        dirty    = (cur != sent);
        ka       = (timer == KA_MAX);
        start    = tx_ready && ((state == S_WAIT) || (state == S_IDLE && (dirty || ka)));
        if (state == S_CHAN && ch != LAST_CH) begin
            word_idx = ch + 8'd1;
        end
        btn_ext[BTN_W-1:0] = sent[word_idx*BTN_W +: BTN_W];
        header_word = {seq, NUM_CH_B};
        chan_word   = {word_idx, btn_ext};
    end

    // Packet FSM; all bus outputs are registered on the state transitions.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            axiov   <= 1'b0;
            axiod   <= '0;
            seq_out <= 8'd0;
            seq     <= 8'd0;
            sent    <= '0;
            timer   <= '0;
            gap_cnt <= '0;
            ch      <= 8'd0;
        end else begin
            case (state)
                S_IDLE, S_WAIT: begin
                    if (start) begin
                        // NOTE: non-blocking assignment makes sent take cur as
                        // it was before this edge, so a sample landing on the
                        // same edge stays dirty for the next packet.
                        sent    <= cur;
                        state   <= S_HEADER;
                        axiov   <= 1'b1;
                        axiod   <= header_word;
                        seq_out <= seq;
                        seq     <= seq + 8'd1;
                        timer   <= '0;
                    end else begin
                        if (timer != KA_MAX) begin
                            timer <= timer + 1'b1;
                        end
                        if (dirty || ka || state == S_WAIT) begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_HEADER: begin
                    state <= S_CHAN;
                    ch    <= 8'd0;
                    axiod <= chan_word;
                end
                S_CHAN: begin
                    if (ch == LAST_CH) begin
                        axiov   <= 1'b0;
                        axiod   <= '0;
                        gap_cnt <= '0;
                        state   <= (GAP_CYCLES > 1) ? S_GAP : S_IDLE;
                    end else begin
                        ch    <= ch + 8'd1;
                        axiod <= chan_word;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    axiov <= 1'b0;
                    axiod <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controller_packetizer.sv
// Directed bench for controller_packetizer with a short keepalive and gap.

module tb_controller_packetizer;

    localparam int NUM_CH = 2;
    localparam int BTN_W  = 8;
    localparam int KA     = 40;
    localparam int GAP    = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [NUM_CH-1:0]       ch_valid = '0;
    logic [NUM_CH*BTN_W-1:0] ch_buttons = '0;
    logic                    tx_ready = 1'b1;
    logic                    axiov;
    logic [15:0]             axiod;
    logic [7:0]              seq_out;

    int n_checks = 0;
    int n_fails  = 0;

    controller_packetizer #(
        .NUM_CH(NUM_CH),
        .BTN_W(BTN_W),
        .WORD_W(16),
        .KEEPALIVE_CYCLES(KA),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ch_valid(ch_valid),
        .ch_buttons(ch_buttons),
        .tx_ready(tx_ready),
        .axiov(axiov),
        .axiod(axiod),
        .seq_out(seq_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Waits on falling edges until axiov is seen; low counts idle edges.
    task automatic wait_header(input int max_cycles, output int low, output bit seen);
        low  = 0;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (axiov) begin
                seen = 1'b1;
                break;
            end
            low++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tx_ready = 1'b1;
        ch_valid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (axiov !== 1'b0) begin n_fails++; $display("FAIL reset_axiov got=%b exp=0", axiov); end
        n_checks++;
        if (axiod !== 16'h0000) begin n_fails++; $display("FAIL reset_axiod got=%h exp=0000", axiod); end
        n_checks++;
        if (seq_out !== 8'h00) begin n_fails++; $display("FAIL reset_seq_out got=%h exp=00", seq_out); end
        rst = 1'b1;
    endtask

    task automatic test_first_packet();
        int low; bit seen;
        ch_buttons = {8'h00, 8'h01};
        ch_valid   = 2'b01;
        @(negedge clk);
        ch_valid = '0;
        wait_header(5, low, seen);
        n_checks++;
        if (!seen || low !== 0) begin n_fails++; $display("FAIL first_latency seen=%b low=%0d exp_low=0", seen, low); end
        n_checks++;
        if (axiod !== 16'h0002) begin n_fails++; $display("FAIL first_header got=%h exp=0002", axiod); end
        @(negedge clk);
        n_checks++;
        if ({axiov, axiod} !== {1'b1, 16'h0001}) begin n_fails++; $display("FAIL first_word1 got=%b/%h exp=1/0001", axiov, axiod); end
        @(negedge clk);
        n_checks++;
        if ({axiov, axiod} !== {1'b1, 16'h0100}) begin n_fails++; $display("FAIL first_word2 got=%b/%h exp=1/0100", axiov, axiod); end
        @(negedge clk);
        n_checks++;
        if ({axiov, axiod} !== {1'b0, 16'h0000}) begin n_fails++; $display("FAIL first_end got=%b/%h exp=0/0000", axiov, axiod); end
        n_checks++;
        if (seq_out !== 8'h00) begin n_fails++; $display("FAIL first_seq_out got=%h exp=00", seq_out); end
    endtask

    // Same values resampled every cycle: only the keepalive fires, after
    // GAP-1 gap cycles plus KA idle cycles; one low edge was already seen.
    task automatic test_keepalive();
        int low; bit seen;
        ch_buttons = {8'h00, 8'h01};
        ch_valid   = 2'b11;
        wait_header(100, low, seen);
        ch_valid = '0;
        n_checks++;
        if (!seen || low !== (GAP - 1 + KA - 1)) begin
            n_fails++; $display("FAIL ka_delay seen=%b low=%0d exp=%0d", seen, low, GAP - 1 + KA - 1);
        end
        n_checks++;
        if (axiod !== 16'h0102) begin n_fails++; $display("FAIL ka_header got=%h exp=0102", axiod); end
        @(negedge clk);
        n_checks++;
        if ({axiov, axiod} !== {1'b1, 16'h0001}) begin n_fails++; $display("FAIL ka_word1 got=%b/%h exp=1/0001", axiov, axiod); end
        @(negedge clk);
        n_checks++;
        if ({axiov, axiod} !== {1'b1, 16'h0100}) begin n_fails++; $display("FAIL ka_word2 got=%b/%h exp=1/0100", axiov, axiod); end
        @(negedge clk);
        n_checks++;
        if (seq_out !== 8'h01) begin n_fails++; $display("FAIL ka_seq_out got=%h exp=01", seq_out); end
    endtask

    task automatic test_tx_ready_hold();
        int low; bit seen; bit saw_v;
        tx_ready   = 1'b0;
        ch_buttons = {8'hA5, 8'h01};
        ch_valid   = 2'b10;
        @(negedge clk);
        ch_valid = '0;
        saw_v = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (axiov) saw_v = 1'b1;
        end
        n_checks++;
        if (saw_v !== 1'b0) begin n_fails++; $display("FAIL hold_no_tx got=%b exp=0", saw_v); end
        tx_ready = 1'b1;
        wait_header(3, low, seen);
        n_checks++;
        if (!seen || low !== 0) begin n_fails++; $display("FAIL hold_release seen=%b low=%0d exp_low=0", seen, low); end
        n_checks++;
        if (axiod !== 16'h0202) begin n_fails++; $display("FAIL hold_header got=%h exp=0202", axiod); end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({axiov, axiod} !== {1'b1, 16'h01A5}) begin n_fails++; $display("FAIL hold_word2 got=%b/%h exp=1/01A5", axiov, axiod); end
        @(negedge clk);
        n_checks++;
        if (seq_out !== 8'h02) begin n_fails++; $display("FAIL hold_seq_out got=%h exp=02", seq_out); end
    endtask

    // A sample during the header cycle misses this packet and triggers the
    // next one exactly GAP cycles after the last word.
    task automatic test_snapshot();
        int low; bit seen;
        repeat (8) @(negedge clk);
        ch_buttons = {8'hA5, 8'h11};
        ch_valid   = 2'b01;
        @(negedge clk);
        ch_valid = '0;
        wait_header(3, low, seen);
        n_checks++;
        if (!seen || axiod !== 16'h0302) begin n_fails++; $display("FAIL snap_header1 seen=%b got=%h exp=0302", seen, axiod); end
        ch_buttons = {8'hA5, 8'h22};
        ch_valid   = 2'b01;
        @(negedge clk);
        ch_valid = '0;
        n_checks++;
        if ({axiov, axiod} !== {1'b1, 16'h0011}) begin n_fails++; $display("FAIL snap_old_value got=%b/%h exp=1/0011", axiov, axiod); end
        @(negedge clk);
        n_checks++;
        if ({axiov, axiod} !== {1'b1, 16'h01A5}) begin n_fails++; $display("FAIL snap_word2 got=%b/%h exp=1/01A5", axiov, axiod); end
        wait_header(20, low, seen);
        n_checks++;
        if (!seen || low !== GAP) begin n_fails++; $display("FAIL snap_gap seen=%b low=%0d exp=%0d", seen, low, GAP); end
        n_checks++;
        if (axiod !== 16'h0402) begin n_fails++; $display("FAIL snap_header2 got=%h exp=0402", axiod); end
        @(negedge clk);
        n_checks++;
        if ({axiov, axiod} !== {1'b1, 16'h0022}) begin n_fails++; $display("FAIL snap_new_value got=%b/%h exp=1/0022", axiov, axiod); end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({axiov, axiod} !== {1'b0, 16'h0000}) begin n_fails++; $display("FAIL snap_end got=%b/%h exp=0/0000", axiov, axiod); end
    endtask

    // Packets with seq 5..255 and then 0: the header high byte must wrap.
    task automatic test_seq_wrap();
        int low; bit seen;
        logic [7:0] exp_seq;
        exp_seq = 8'd5;
        for (int n = 0; n < 252; n++) begin
            ch_buttons = {8'hA5, (n % 2 == 0) ? 8'h33 : 8'h22};
            ch_valid   = 2'b01;
            @(negedge clk);
            ch_valid = '0;
            wait_header(20, low, seen);
            n_checks++;
            if (!seen || axiod[15:8] !== exp_seq) begin
                n_fails++; $display("FAIL wrap_seq seen=%b got=%h exp=%h", seen, axiod[15:8], exp_seq);
            end
            repeat (3) @(negedge clk);
            exp_seq = exp_seq + 8'd1;
        end
        n_checks++;
        if (seq_out !== 8'h00) begin n_fails++; $display("FAIL wrap_seq_out got=%h exp=00", seq_out); end
    endtask

    task automatic test_reset_mid_packet();
        int low; bit seen; bit saw_v;
        ch_buttons = {8'hA5, 8'h44};
        ch_valid   = 2'b01;
        @(negedge clk);
        ch_valid = '0;
        wait_header(20, low, seen);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({axiov, axiod} !== {1'b0, 16'h0000}) begin n_fails++; $display("FAIL rstmid_bus got=%b/%h exp=0/0000", axiov, axiod); end
        n_checks++;
        if (seq_out !== 8'h00) begin n_fails++; $display("FAIL rstmid_seq_out got=%h exp=00", seq_out); end
        rst = 1'b1;
        saw_v = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (axiov) saw_v = 1'b1;
        end
        n_checks++;
        if (!seen || saw_v !== 1'b0) begin n_fails++; $display("FAIL rstmid_resume seen=%b got=%b exp=0", seen, saw_v); end
    endtask

    // A change that reverts before the next trigger point sends nothing.
    task automatic test_revert();
        int low; bit seen; bit saw_v;
        ch_buttons = {8'h5A, 8'h00};
        ch_valid   = 2'b10;
        @(negedge clk);
        ch_valid = '0;
        wait_header(3, low, seen);
        n_checks++;
        if (!seen || axiod !== 16'h0002) begin n_fails++; $display("FAIL revert_header seen=%b got=%h exp=0002", seen, axiod); end
        ch_buttons = {8'h77, 8'h00};
        ch_valid   = 2'b10;
        @(negedge clk);
        ch_buttons = {8'h5A, 8'h00};
        @(negedge clk);
        ch_valid = '0;
        n_checks++;
        if ({axiov, axiod} !== {1'b1, 16'h015A}) begin n_fails++; $display("FAIL revert_word2 got=%b/%h exp=1/015A", axiov, axiod); end
        saw_v = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (axiov) saw_v = 1'b1;
        end
        n_checks++;
        if (saw_v !== 1'b0) begin n_fails++; $display("FAIL revert_no_packet got=%b exp=0", saw_v); end
    endtask

    initial begin
        test_reset();
        test_first_packet();
        test_keepalive();
        test_tx_ready_hold();
        test_snapshot();
        test_seq_wrap();
        test_reset_mid_packet();
        test_revert();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
